// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver FSM state encoding and the
//               bit-period helper. The system clock frequency comes from the
//               FCLK macro; the default is 1.8432 MHz (16 x 115200).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef FCLK
`define FCLK 1843200
`endif

package uart_pkg;

    // Receiver FSM states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Bit period in system clock cycles (integer division, truncating).
    function automatic int unsigned ticks_per_bit(input int unsigned bauds);
        return `FCLK / bauds;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_timer.sv
// ============================================================================
// Module      : uart_baud_timer
// Description : Loadable down-counter with zero flag. Holds at zero until it
//               is reloaded; the load value is the number of cycles to wait
//               minus one. Shared between the UART receiver and transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_baud_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Reload on request, otherwise count down and rest at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : UART receiver. Frame = 1 start bit (0), W data bits LSB first,
//               Wstop stop bits (1). The line is sampled at mid-bit; a good
//               frame updates OUT with a one-cycle VALID strobe, a stop bit
//               sampled low gives a one-cycle FERR strobe and leaves OUT as is.
//               Optional macro UART_RX_SYNC_EN inserts a 2-flop synchronizer
//               on RX (adds 2 cycles of latency to every timing).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int Bauds = 115200,
    parameter int W     = 8,
    parameter int Wstop = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         RX,
    output logic [W-1:0] OUT,
    output logic         VALID,
    output logic         FERR
);

    localparam int unsigned NTICKS = ticks_per_bit(Bauds);
    localparam int          CNT_W  = $bits(NTICKS);
    localparam int          IDX_W  = $bits(W + Wstop);

    // Half period lands the first sample in the middle of the start bit,
    // full period steps from one mid-bit to the next.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(NTICKS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(NTICKS - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(Wstop - 1);

    logic             rx_s;
    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     shreg;
    logic             err;
    logic             wait_high;
    logic             tick;
    logic             start_det;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             go_data;
    logic             shift_en;
    logic             stop_en;
    logic             frame_end;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], RX};
        end
    end

    assign rx_s = sync[1];
`else
    assign rx_s = RX;
`endif

    uart_baud_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (CLK),
        .rst_n      (RST_N),
        .load       (tmr_load),
        .load_value (tmr_value),
        .zero       (tick)
    );

    // A low line only counts as a start edge once it has been seen high
    // after a frame that ended with the line low (break condition).
    assign start_det = (state == IDLE) && !rx_s && !wait_high;

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_det) next_state = START;
            START:   if (tick) next_state = rx_s ? IDLE : DATA;
            DATA:    if (tick && (idx == LAST_DATA)) next_state = STOP;
            STOP:    if (tick && (idx == LAST_STOP)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Per-state control: timer reloads and sample enables.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = FULL_LOAD;
        go_data   = 1'b0;
        shift_en  = 1'b0;
        stop_en   = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                if (start_det) begin
                    tmr_load  = 1'b1;
                    tmr_value = HALF_LOAD;
                end
            end
            START: begin
                if (tick && !rx_s) begin
                    go_data  = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    stop_en   = 1'b1;
                    tmr_load  = 1'b1;
                    frame_end = (idx == LAST_STOP);
                end
            end
            default: ;
        endcase
    end

    // Datapath: bit index, shift register, error flag and output strobes.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            idx       <= '0;
            shreg     <= '0;
            err       <= 1'b0;
            wait_high <= 1'b0;
            OUT       <= '0;
            VALID     <= 1'b0;
            FERR      <= 1'b0;
        end else begin
            VALID <= 1'b0;
            FERR  <= 1'b0;

            if ((state == IDLE) && rx_s) begin
                wait_high <= 1'b0;
            end

            if (go_data) begin
                idx <= '0;
                err <= 1'b0;
            end

            if (shift_en) begin
                // LSB arrives first, so shift in from the top.
                shreg <= (shreg >> 1) | (W'(rx_s) << (W - 1));
                idx   <= (idx == LAST_DATA) ? '0 : idx + 1'b1;
            end

            if (stop_en) begin
                if (frame_end) begin
                    idx <= '0;
                    err <= 1'b0;
                    if (err || !rx_s) begin
                        FERR <= 1'b1;
                    end else begin
                        VALID <= 1'b1;
                        OUT   <= shreg;
                    end
                    // Line still low at the last stop sample: treat as break
                    // and hold off until it returns high.
                    wait_high <= !rx_s;
                end else begin
                    idx <= idx + 1'b1;
                    if (!rx_s) begin
                        err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
